// File: rtl/edge_capture_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : edge_capture_unit_if
//  Description : Control/status bundle for edge_capture_unit; master drives
//                the controls, slave (the capture unit) returns edge status.
//  Revision    : 1.0
// ============================================================================
interface edge_capture_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] irq_mask;
    logic             count_clr;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] sticky;
    logic             irq;
    logic [CNT_W-1:0] evt_count;
    logic             ovf;

    modport master (
        output en, mode, din, clr, irq_mask, count_clr,
        input  pulse, sticky, irq, evt_count, ovf
    );

    modport slave (
        input  en, mode, din, clr, irq_mask, count_clr,
        output pulse, sticky, irq, evt_count, ovf
    );
endinterface
`default_nettype wire

// File: rtl/edge_capture_unit.sv
`default_nettype none
// ============================================================================
//  Module      : edge_capture_unit
//  Description : Multi-channel rising/falling edge detector with one-cycle
//                pulses, W1C sticky flags, irq summary and saturating event
//                counter. Define EDGE_CAPTURE_SYNC_EN to add a 2-flop din
//                synchroniser with a priming fill delay.
//  Revision    : 1.0
// ============================================================================
module edge_capture_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input wire            clk,
    input wire            rst_n,
    edge_capture_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_din;
    logic             w_fill_done;

`ifdef EDGE_CAPTURE_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [1:0]       r_fill;

    // Fill counter keeps priming off until the synchroniser holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_fill  <= 2'd0;
        end else begin
            r_sync1 <= bus.din;
            r_sync2 <= r_sync1;
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
        end
    end

    assign w_din       = r_sync2;
    assign w_fill_done = (r_fill == 2'd2);
`else
    assign w_din       = bus.din;
    assign w_fill_done = 1'b1;
`endif

    logic [WIDTH-1:0] r_prev;
    logic             r_primed;
    logic [WIDTH-1:0] r_pulse;
    logic [WIDTH-1:0] r_sticky;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_det;
    logic [CNT_W-1:0] w_pc;
    logic [CNT_W:0]   w_sum;

    assign w_rise = w_din & ~r_prev;
    assign w_fall = ~w_din & r_prev;

    always_comb begin
        w_det = '0;
        if (bus.en && r_primed) begin
            w_det = (bus.mode[0] ? w_rise : '0) | (bus.mode[1] ? w_fall : '0);
        end
    end

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pc = w_pc + {{(CNT_W-1){1'b0}}, w_det[i]};
        end
    end

    // One extra bit so a wrap is visible as saturation rather than lost
    assign w_sum = {1'b0, r_count} + {1'b0, w_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_pulse  <= '0;
            r_sticky <= '0;
        end else begin
            r_prev   <= w_din;
            r_primed <= r_primed | (bus.en & w_fill_done);
            r_pulse  <= w_det;
            r_sticky <= (r_sticky & ~bus.clr) | w_det;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.count_clr) begin
            r_count <= w_pc;
            r_ovf   <= 1'b0;
        end else if (w_sum[CNT_W]) begin
            r_count <= c_CNT_MAX;
            r_ovf   <= 1'b1;
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign bus.pulse     = r_pulse;
    assign bus.sticky    = r_sticky;
    assign bus.irq       = |(r_sticky & bus.irq_mask);
    assign bus.evt_count = r_count;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_capture_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_capture_unit
//  Description : Scoreboard bench for edge_capture_unit (WIDTH=8, CNT_W=4).
//  Revision    : 1.0
// ============================================================================
module tb_edge_capture_unit;
    typedef struct packed {
        logic [7:0] pulse;
        logic [7:0] sticky;
        logic       irq;
        logic [3:0] cnt;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   n_step;
    exp_t exp_q[$];

    edge_capture_unit_if #(.WIDTH(8), .CNT_W(4)) bus ();

    edge_capture_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, n_step, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic [7:0] d,
                        input logic [7:0] c, input logic [7:0] mk, input logic cc,
                        input logic [7:0] ep, input logic [7:0] es, input logic ei,
                        input logic [3:0] ec, input logic eo);
        exp_t x;
        @(negedge clk);
        bus.en        = e;
        bus.mode      = m;
        bus.din       = d;
        bus.clr       = c;
        bus.irq_mask  = mk;
        bus.count_clr = cc;
        x.pulse  = ep;
        x.sticky = es;
        x.irq    = ei;
        x.cnt    = ec;
        x.ovf    = eo;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"},  32'(bus.pulse),     32'h0);
        check({tag, "_sticky"}, 32'(bus.sticky),    32'h0);
        check({tag, "_irq"},    32'(bus.irq),       32'h0);
        check({tag, "_cnt"},    32'(bus.evt_count), 32'h0);
        check({tag, "_ovf"},    32'(bus.ovf),       32'h0);
    endtask

    // Monitor: one expectation per clock, compared just after the edge
    initial begin
        exp_t x;
        n_step = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                n_step++;
                check("pulse",  32'(bus.pulse),     32'(x.pulse));
                check("sticky", 32'(bus.sticky),    32'(x.sticky));
                check("irq",    32'(bus.irq),       32'(x.irq));
                check("count",  32'(bus.evt_count), 32'(x.cnt));
                check("ovf",    32'(bus.ovf),       32'(x.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 2'b00; bus.din = 8'h00; bus.clr = 8'h00;
        bus.irq_mask = 8'h00; bus.count_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
`ifdef EDGE_CAPTURE_SYNC_EN
        bus.din = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        // Fill period: no pulses despite din=FF against zeroed sync flops
        step(1, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0, 0);
        step(1, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0, 0);
        step(1, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0, 0);
        step(1, 2'b10, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0, 0);
        // Fall seen on the third edge after the raw change
        step(1, 2'b10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0, 0);
        step(1, 2'b10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0, 0);
        step(1, 2'b10, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 0, 4'd8, 0);
        step(1, 2'b10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'hFF, 0, 4'd8, 0);
        drain();
`else
        @(negedge clk);
        rst_n = 1'b1;
        //   en mode   din    clr    mask   cc  pulse  sticky irq cnt ovf
        step(1, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b01, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 0, 4'd8,  0);
        step(1, 2'b01, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'hFF, 0, 4'd8,  0);
        step(1, 2'b01, 8'h0F, 8'hFF, 8'h00, 1, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b10, 8'h05, 8'h00, 8'h00, 0, 8'h0A, 8'h0A, 0, 4'd2,  0);
        step(1, 2'b11, 8'h50, 8'h00, 8'h00, 0, 8'h55, 8'h5F, 0, 4'd6,  0);
        step(1, 2'b11, 8'h50, 8'h00, 8'h00, 0, 8'h00, 8'h5F, 0, 4'd6,  0);
        // Sticky set beats simultaneous clear
        step(1, 2'b01, 8'h50, 8'hFF, 8'h00, 1, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b01, 8'h51, 8'h00, 8'h00, 0, 8'h01, 8'h01, 0, 4'd1,  0);
        step(1, 2'b01, 8'h50, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0, 4'd1,  0);
        step(1, 2'b01, 8'h51, 8'h01, 8'h00, 0, 8'h01, 8'h01, 0, 4'd2,  0);
        step(1, 2'b01, 8'h51, 8'h01, 8'h00, 0, 8'h00, 8'h00, 0, 4'd2,  0);
        step(1, 2'b01, 8'h50, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd2,  0);
        step(1, 2'b01, 8'h51, 8'h00, 8'h01, 0, 8'h01, 8'h01, 1, 4'd3,  0);
        step(1, 2'b01, 8'h51, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0, 4'd3,  0);
        // Counter: clear-then-add, saturation, clear during toggle, exact max
        step(1, 2'b11, 8'h00, 8'hFF, 8'h00, 1, 8'h51, 8'h51, 0, 4'd3,  0);
        step(1, 2'b11, 8'hFF, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 0, 4'd11, 0);
        step(1, 2'b11, 8'h00, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 0, 4'd15, 1);
        step(1, 2'b11, 8'hFF, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 0, 4'd15, 1);
        step(1, 2'b11, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 0, 4'd8,  0);
        step(1, 2'b11, 8'hF8, 8'h00, 8'h00, 0, 8'hF8, 8'hFF, 0, 4'd13, 0);
        step(1, 2'b11, 8'hFA, 8'h00, 8'h00, 0, 8'h02, 8'hFF, 0, 4'd14, 0);
        step(1, 2'b11, 8'hFB, 8'h00, 8'h00, 0, 8'h01, 8'hFF, 0, 4'd15, 0);
        step(1, 2'b11, 8'hFB, 8'h00, 8'h00, 0, 8'h00, 8'hFF, 0, 4'd15, 0);
        // Disabled: clr still works, no detection
        step(0, 2'b11, 8'h04, 8'hFF, 8'h00, 1, 8'h00, 8'h00, 0, 4'd0,  0);
        step(0, 2'b11, 8'hFB, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        step(0, 2'b11, 8'h04, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b11, 8'h04, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b11, 8'h05, 8'h00, 8'h00, 0, 8'h01, 8'h01, 0, 4'd1,  0);
        step(1, 2'b11, 8'hFA, 8'h00, 8'hFF, 0, 8'hFF, 8'hFF, 1, 4'd9,  0);
        drain();
        // Asynchronous reset in the middle of a cycle
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 2'b11, 8'hFA, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        step(1, 2'b11, 8'hFA, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0, 4'd0,  0);
        drain();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/edge_capture_unit.md
Name: edge_capture_unit

Overview:
- Parametrised multi-channel edge detector: WIDTH independent input bits, runtime-selectable rising/falling/both detection.
- Produces registered one-cycle edge pulses, per-channel sticky capture flags with write-1-to-clear, an interrupt summary and a saturating edge-event counter.
- Sits between raw status/GPIO-style inputs and control logic or CSR readback, replacing single-width, rising-only edge registers.

Parameters:
- WIDTH, 8, number of input channels.
- CNT_W, 16, event counter width; must be >= $clog2(WIDTH+1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  detection enable.
- mode  input  2  00 none, 01 rising, 10 falling, 11 both.
- din  input  WIDTH  sampled input channels.
- clr  input  WIDTH  per-channel sticky clear, write-1-to-clear, level-sampled each cycle.
- irq_mask  input  WIDTH  per-channel interrupt enable.
- count_clr  input  1  synchronous clear of evt_count and ovf.
- pulse  output  WIDTH  one-cycle registered edge pulse per channel.
- sticky  output  WIDTH  latched edge flags.
- irq  output  1  |(sticky & irq_mask), combinational from registers.
- evt_count  output  CNT_W  saturating total detected-edge count.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Reset (rst_n low, asynchronous): prev=0, primed=0, pulse=0, sticky=0, evt_count=0, ovf=0; irq therefore 0.
- prev register loads din every cycle, regardless of en.
- primed:
  - Set on the first cycle with en=1 after reset; cleared only by reset.
  - While primed=0, no edges are detected; prev still loads din.
  - This blocks a spurious edge against the reset value of prev.
- det vector, valid only when en=1 and primed=1:
  - rise = din & ~prev; fall = ~din & prev.
  - det = (mode[0] ? rise : 0) | (mode[1] ? fall : 0).
  - When en=0 or primed=0, det=0.
- Latency: din changes before clock edge N; pulse asserts after edge N and lasts exactly one cycle, unless a further edge is detected at N+1.
- pulse <= det, registered. Toggling din every cycle with mode=11 gives pulse held high continuously.
- sticky <= (sticky & ~clr) | det. Set wins over a simultaneous clr on the same bit. clr still operates while en=0.
- mode changes take effect at the next clock edge. Switching mode does not generate edges, since prev is always current.
- Event counter:
  - pc = popcount(det), range 0..WIDTH.
  - count_clr=1: evt_count <= pc and ovf <= 0. Clear-then-add, so edges in the clearing cycle are not lost.
  - Else if evt_count + pc > 2^CNT_W-1: evt_count <= 2^CNT_W-1 (saturate) and ovf <= 1.
  - Else evt_count <= evt_count + pc.
  - Addition is done at CNT_W+1 bits.
  - ovf holds until count_clr or reset. Reaching exactly the max value does not set ovf.
- Reset mid-operation: all state clears immediately; primed=0, so the first en cycle after release re-primes without detection.

Optional Feature:
- Macro EDGE_CAPTURE_SYNC_EN.
- Defined:
  - din passes through a 2-flop synchroniser per bit, reset to 0; detection uses the synchronised value.
  - Latency from the raw din change to pulse becomes 3 clock edges.
  - primed sets only on an en=1 cycle occurring at least 2 cycles after rst_n release. A 2-bit fill counter saturates at 2, so synchroniser reset values cannot cause false edges.
- Undefined: no synchroniser; din is assumed synchronous to clk; priming as above with no fill delay.

Test Plan:
- Reset release with din=8'hFF, en=1, mode=01 -> first en cycle primes, pulse=0, sticky=0, evt_count=0; din drops to 8'h00 and back to 8'hFF -> pulse=8'hFF for exactly one cycle after the rise, sticky=8'hFF, evt_count=8.
- mode=10, din 8'h0F->8'h05 -> pulse=8'h0A for one cycle; mode=11 with din 8'h05->8'h50 -> pulse=8'h55, evt_count increases by 4.
- sticky=8'h01 and clr=8'h01 in the same cycle as a new rising edge on bit0 -> sticky bit0 remains 1; next cycle with clr=8'h01 and no edge -> bit0=0. irq_mask=8'h00 -> irq=0 throughout.
- CNT_W=4, WIDTH=8, mode=11: drive full 8'h00/8'hFF toggles -> evt_count 8, then saturates at 15 with ovf=1; count_clr asserted during a toggle -> evt_count=8, ovf=0.
- en=0 while din toggles -> pulse=0, sticky and evt_count unchanged; en=1 with din stable -> no pulse.
- Assert rst_n low mid-burst -> outputs 0 asynchronously; with EDGE_CAPTURE_SYNC_EN defined and din=8'hFF at release -> no pulse during synchroniser fill, and a 8'hFF->8'h00 change later produces pulse 3 edges after the change (mode=10).
